// File: rtl/fft_pkg.sv
// Shared definitions for the 64-point in-place FFT sequencer: sizes, FSM states,
// butterfly address bundle and the bit-reversal helper.
package fft_pkg;
   localparam int N_LOG2 = 6;
   localparam int N      = 2 ** N_LOG2;
   localparam int ADDR_W = N_LOG2;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMP, S_UNLD} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [ADDR_W-1:0] b;
      logic [ADDR_W-2:0] tw;
   } bf_addr_t;

   function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] x);
      logic [ADDR_W-1:0] r;
      for (int i = 0; i < ADDR_W; i++) r[i] = x[ADDR_W-1-i];
      return r;
   endfunction
endpackage

// File: rtl/fft_addr_delay.sv
// Fixed-depth shift register with asynchronous clear; aligns control and addresses
// with the butterfly and RAM latencies.
module fft_addr_delay #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_nrst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);
   logic [WIDTH-1:0] r_sr [DEPTH];

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
      end else begin
         r_sr[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
      end
   end

   assign o_q = r_sr[DEPTH-1];
endmodule

// File: rtl/fft_inplace_seq.sv
// Address/control sequencer for a 64-point radix-2 DIT in-place FFT: bit-reversed
// load, 6 stages of butterfly read/write pairs with twiddle indices, paired unload.
module fft_inplace_seq
   import fft_pkg::*;
#(
   parameter int BF_LAT  = 3,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              start,
   input  logic              valid,
   output logic              busy,
   output logic              load_we,
   output logic [ADDR_W-1:0] load_addr,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr_a,
   output logic [ADDR_W-1:0] rd_addr_b,
   output logic [ADDR_W-2:0] tw_idx,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr_a,
   output logic [ADDR_W-1:0] wr_addr_b,
   output logic [2:0]        stage,
   output logic              out_valid,
   output logic              done
);
   localparam logic [ADDR_W-1:0] HALF      = ADDR_W'(N / 2);
   localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'(N - 1);
   localparam logic [ADDR_W-1:0] COMP_LAST = ADDR_W'(N / 2 + BF_LAT - 1);
   localparam logic [ADDR_W-1:0] UNLD_LAST = ADDR_W'(N / 2 + MEM_LAT - 1);
   localparam logic [2:0]        STG_LAST  = 3'(N_LOG2 - 1);

   state_t            r_state, w_state_nx;
   logic [ADDR_W-1:0] r_cnt, w_cnt_nx;
   logic [2:0]        r_stage, w_stage_nx;
   logic              r_crd, r_urd, r_done;
   logic [ADDR_W-1:0] r_rd_a, r_rd_b;
   logic [ADDR_W-2:0] r_tw;
   logic              w_crd, w_urd;
   logic [ADDR_W-1:0] w_rd_a, w_rd_b;
   logic [ADDR_W-2:0] w_tw;
   bf_addr_t          w_bf;

   function automatic bf_addr_t bf_decode(input logic [2:0] stg, input logic [ADDR_W-1:0] j);
      logic [ADDR_W-1:0] half, pos;
      bf_addr_t          r;
      half = ADDR_W'(1) << stg;
      pos  = j & (half - ADDR_W'(1));
      r.a  = ((j >> stg) << (stg + 3'd1)) + pos;
      r.b  = r.a + half;
      r.tw = (ADDR_W-1)'(pos << (STG_LAST - stg));
      return r;
   endfunction

   // One shared counter: load index, position within a stage (incl. drain), unload index
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_stage_nx = r_stage;
      case (r_state)
         S_IDLE: if (start) begin
            w_state_nx = S_LOAD;
            w_cnt_nx   = '0;
         end
         S_LOAD: if (valid) begin
            w_cnt_nx = r_cnt + ADDR_W'(1);
            if (r_cnt == LOAD_LAST) w_state_nx = S_COMP;
         end
         S_COMP: begin
            if (r_cnt == COMP_LAST) begin
               w_cnt_nx = '0;
               if (r_stage == STG_LAST) begin
                  w_state_nx = S_UNLD;
                  w_stage_nx = '0;
               end else begin
                  w_stage_nx = r_stage + 3'd1;
               end
            end else begin
               w_cnt_nx = r_cnt + ADDR_W'(1);
            end
         end
         S_UNLD: begin
            if (r_cnt == UNLD_LAST) begin
               w_state_nx = S_IDLE;
               w_cnt_nx   = '0;
            end else begin
               w_cnt_nx = r_cnt + ADDR_W'(1);
            end
         end
         default: begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
            w_stage_nx = '0;
         end
      endcase
   end

   // Read strobes/addresses are decoded from the next counter values so they leave a register
   always_comb begin
      w_crd  = (w_state_nx == S_COMP) && (w_cnt_nx < HALF);
      w_urd  = (w_state_nx == S_UNLD) && (w_cnt_nx < HALF);
      w_bf   = bf_decode(w_stage_nx, w_cnt_nx);
      w_rd_a = '0;
      w_rd_b = '0;
      w_tw   = '0;
      if (w_crd) begin
         w_rd_a = w_bf.a;
         w_rd_b = w_bf.b;
         w_tw   = w_bf.tw;
      end else if (w_urd) begin
         w_rd_a = {w_cnt_nx[ADDR_W-2:0], 1'b0};
         w_rd_b = {w_cnt_nx[ADDR_W-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_stage <= '0;
         r_crd   <= 1'b0;
         r_urd   <= 1'b0;
         r_rd_a  <= '0;
         r_rd_b  <= '0;
         r_tw    <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_stage <= w_stage_nx;
         r_crd   <= w_crd;
         r_urd   <= w_urd;
         r_rd_a  <= w_rd_a;
         r_rd_b  <= w_rd_b;
         r_tw    <= w_tw;
         r_done  <= (w_state_nx == S_UNLD) && (w_cnt_nx == UNLD_LAST);
      end
   end

   // Only butterfly reads produce write-backs; unload reads feed out_valid instead
   fft_addr_delay #(.DEPTH(BF_LAT), .WIDTH(2 * ADDR_W + 1)) u_wr_dly (
      .i_clk  (clk),
      .i_nrst (nrst),
      .i_d    ({r_crd, r_rd_a, r_rd_b}),
      .o_q    ({wr_en, wr_addr_a, wr_addr_b})
   );

   fft_addr_delay #(.DEPTH(MEM_LAT), .WIDTH(1)) u_ov_dly (
      .i_clk  (clk),
      .i_nrst (nrst),
      .i_d    (r_urd),
      .o_q    (out_valid)
   );

   assign busy      = (r_state != S_IDLE);
   assign load_we   = (r_state == S_LOAD) && valid;
   assign load_addr = (r_state == S_LOAD) ? bitrev(r_cnt) : '0;
   assign rd_en     = r_crd | r_urd;
   assign rd_addr_a = r_rd_a;
   assign rd_addr_b = r_rd_b;
   assign tw_idx    = r_tw;
   assign stage     = r_stage;
   assign done      = r_done;
endmodule

// File: tb/tb_fft_inplace_seq.sv
// Randomized bench for fft_inplace_seq: cycle-level behavioural model of the sequencer
// plus a RAM/butterfly model whose unloaded bins are compared with a direct DFT.
module tb_fft_inplace_seq;
   import fft_pkg::*;

   localparam int BF  = 3;
   localparam int ML  = 1;
   localparam int PER = 32 + BF;

   logic       clk = 1'b0, nrst = 1'b0, start = 1'b0, valid = 1'b0;
   logic       busy, load_we, rd_en, wr_en, out_valid, done;
   logic [5:0] load_addr, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [4:0] tw_idx;
   logic [2:0] stage;

   always #5 clk = ~clk;

   fft_inplace_seq #(.BF_LAT(BF), .MEM_LAT(ML)) dut (
      .clk(clk), .nrst(nrst), .start(start), .valid(valid), .busy(busy),
      .load_we(load_we), .load_addr(load_addr), .rd_en(rd_en), .rd_addr_a(rd_addr_a),
      .rd_addr_b(rd_addr_b), .tw_idx(tw_idx), .wr_en(wr_en), .wr_addr_a(wr_addr_a),
      .wr_addr_b(wr_addr_b), .stage(stage), .out_valid(out_valid), .done(done)
   );

   int n_err = 0, n_chk = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_r(input string nm, input real act, input real exp);
      real d;
      n_chk++;
      d = act - exp;
      if (d < 0.0) d = -d;
      if (d > 1.0e-6) begin
         n_err++;
         $display("FAIL %s: got %f expected %f at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int rev6(input int x);
      int r = 0;
      for (int i = 0; i < 6; i++) if (((x >> i) & 1) != 0) r += 1 << (5 - i);
      return r;
   endfunction

   function automatic void bf_ref(input int s, input int j, output int a, output int b, output int tw);
      int half = 1 << s;
      a  = (j / half) * 2 * half + (j % half);
      b  = a + half;
      tw = (j % half) * (32 / half);
   endfunction

   // Model: mode 0 idle, 1 load (cnt = samples accepted), 2 compute (cnt = cycle), 3 unload
   int m_mode = 0, m_cnt = 0;
   int h_we[BF], h_a[BF], h_b[BF], h_ov[ML];

   typedef struct {int a; int b; real ar; real ai; real br; real bi;} pair_t;
   pair_t bf_q[$], ud_q[$];
   real   ram_re[64], ram_im[64], x_re[64], x_im[64];
   real   s_re = 0.0, s_im = 0.0;

   task automatic model_out(output int rd, output int crd, output int urd, output int a,
                            output int b, output int tw, output int stg);
      rd = 0; crd = 0; urd = 0; a = 0; b = 0; tw = 0; stg = 0;
      if (m_mode == 2) begin
         stg = m_cnt / PER;
         if ((m_cnt % PER) < 32) begin
            rd = 1; crd = 1;
            bf_ref(stg, m_cnt % PER, a, b, tw);
         end
      end else if (m_mode == 3 && m_cnt < 32) begin
         rd = 1; urd = 1; a = 2 * m_cnt; b = 2 * m_cnt + 1;
      end
   endtask

   function automatic void dft(input int k, output real re, output real im);
      real th;
      re = 0.0; im = 0.0;
      for (int n = 0; n < 64; n++) begin
         th = 2.0 * 3.14159265358979323846 * real'((n * k) % 64) / 64.0;
         re += x_re[n] * $cos(th) + x_im[n] * $sin(th);
         im += x_im[n] * $cos(th) - x_re[n] * $sin(th);
      end
   endfunction

   always @(posedge clk or negedge nrst) begin : model_blk
      int rd, crd, urd, a, b, tw, stg;
      if (!nrst) begin
         m_mode = 0; m_cnt = 0;
         for (int i = 0; i < BF; i++) begin h_we[i] = 0; h_a[i] = 0; h_b[i] = 0; end
         for (int i = 0; i < ML; i++) h_ov[i] = 0;
         bf_q.delete(); ud_q.delete();
      end else begin
         model_out(rd, crd, urd, a, b, tw, stg);
         for (int i = BF - 1; i > 0; i--) begin h_we[i] = h_we[i-1]; h_a[i] = h_a[i-1]; h_b[i] = h_b[i-1]; end
         h_we[0] = crd; h_a[0] = a; h_b[0] = b;
         for (int i = ML - 1; i > 0; i--) h_ov[i] = h_ov[i-1];
         h_ov[0] = urd;
         case (m_mode)
            0: if (start) begin m_mode = 1; m_cnt = 0; end
            1: if (valid) begin m_cnt++; if (m_cnt == 64) begin m_mode = 2; m_cnt = 0; end end
            2: begin m_cnt++; if (m_cnt == 6 * PER) begin m_mode = 3; m_cnt = 0; end end
            default: begin m_cnt++; if (m_cnt == 32 + ML) begin m_mode = 0; m_cnt = 0; end end
         endcase
      end
   end

   always @(negedge clk) begin : cmp_blk
      int rd, crd, urd, a, b, tw, stg;
      pair_t p;
      real er, ei, tr, ti, wre, wim;
      if (nrst) begin
         model_out(rd, crd, urd, a, b, tw, stg);
         chk("busy", busy, int'(m_mode != 0));
         chk("load_we", load_we, int'(m_mode == 1 && valid));
         chk("load_addr", load_addr, (m_mode == 1) ? rev6(m_cnt) : 0);
         chk("rd_en", rd_en, rd);
         chk("rd_addr_a", rd_addr_a, a);
         chk("rd_addr_b", rd_addr_b, b);
         chk("tw_idx", tw_idx, tw);
         chk("stage", stage, stg);
         chk("wr_en", wr_en, h_we[BF-1]);
         chk("wr_addr_a", wr_addr_a, h_a[BF-1]);
         chk("wr_addr_b", wr_addr_b, h_b[BF-1]);
         chk("out_valid", out_valid, h_ov[ML-1]);
         chk("done", done, int'(m_mode == 3 && m_cnt == 31 + ML));
         if (load_we && m_mode == 1) begin
            ram_re[load_addr] = s_re; ram_im[load_addr] = s_im;
            x_re[m_cnt] = s_re; x_im[m_cnt] = s_im;
         end
         if (wr_en) begin
            if (bf_q.size() == 0) chk("wr_without_rd", 1, 0);
            else begin
               p = bf_q.pop_front();
               ram_re[wr_addr_a] = p.ar; ram_im[wr_addr_a] = p.ai;
               ram_re[wr_addr_b] = p.br; ram_im[wr_addr_b] = p.bi;
            end
         end
         if (rd_en && m_mode == 2) begin
            wre = $cos(2.0 * 3.14159265358979323846 * real'(tw_idx) / 64.0);
            wim = -$sin(2.0 * 3.14159265358979323846 * real'(tw_idx) / 64.0);
            tr = ram_re[rd_addr_b] * wre - ram_im[rd_addr_b] * wim;
            ti = ram_re[rd_addr_b] * wim + ram_im[rd_addr_b] * wre;
            p.a = rd_addr_a; p.b = rd_addr_b;
            p.ar = ram_re[rd_addr_a] + tr; p.ai = ram_im[rd_addr_a] + ti;
            p.br = ram_re[rd_addr_a] - tr; p.bi = ram_im[rd_addr_a] - ti;
            bf_q.push_back(p);
         end
         if (out_valid) begin
            if (ud_q.size() == 0) chk("out_valid_without_rd", 1, 0);
            else begin
               p = ud_q.pop_front();
               dft(p.a, er, ei); chk_r("bin_even_re", p.ar, er); chk_r("bin_even_im", p.ai, ei);
               dft(p.b, er, ei); chk_r("bin_odd_re", p.br, er); chk_r("bin_odd_im", p.bi, ei);
            end
         end
         if (rd_en && m_mode == 3) begin
            p.a = rd_addr_a; p.b = rd_addr_b;
            p.ar = ram_re[rd_addr_a]; p.ai = ram_im[rd_addr_a];
            p.br = ram_re[rd_addr_b]; p.bi = ram_im[rd_addr_b];
            ud_q.push_back(p);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      start = 1'b0; valid = 1'b0;
      repeat (n) step();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);        chk({tag, "_load_we"}, load_we, 0);
      chk({tag, "_load_addr"}, load_addr, 0); chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_rd_addr_a"}, rd_addr_a, 0); chk({tag, "_rd_addr_b"}, rd_addr_b, 0);
      chk({tag, "_tw_idx"}, tw_idx, 0);    chk({tag, "_wr_en"}, wr_en, 0);
      chk({tag, "_wr_addr_a"}, wr_addr_a, 0); chk({tag, "_wr_addr_b"}, wr_addr_b, 0);
      chk({tag, "_stage"}, stage, 0);      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   // vmode: 0 always valid, 1 toggling, 2 random; dmode: 0 impulse, 1 random samples
   task automatic run_frame(input int vmode, input int dmode, input int exp_lat, input bit abort);
      int cyc = 1, first = -1, n_rd = 0, n_ov = 0, n_done = 0;
      bit fin = 1'b0;
      start = 1'b1; valid = 1'b0;
      step();
      start = 1'b0;
      while (!fin && cyc < 3000) begin
         case (vmode)
            0: valid = 1'b1;
            1: valid = (cyc % 2) == 1;
            default: valid = ($urandom_range(0, 3) != 0);
         endcase
         if (dmode == 0) begin
            s_re = (m_mode == 1 && m_cnt == 0) ? 1.0 : 0.0; s_im = 0.0;
         end else begin
            s_re = (real'($urandom_range(0, 255)) - 128.0) / 32.0;
            s_im = (real'($urandom_range(0, 255)) - 128.0) / 32.0;
         end
         if (m_mode == 2 && (m_cnt % 40) == 7) start = 1'b1;
         if (rd_en && first < 0) first = cyc;
         if (rd_en) n_rd++;
         if (out_valid) n_ov++;
         if (abort && stage == 3) begin
            #2 nrst = 1'b0;
            #1 chk_zero("async_rst");
            start = 1'b0; valid = 1'b0;
            step(); step();
            nrst = 1'b1;
            return;
         end
         if (done) begin n_done++; start = 1'b1; fin = 1'b1; end
         step();
         start = 1'b0;
         cyc++;
      end
      if (abort) chk("abort_point_reached", 0, 1);
      chk("frame_finished", int'(fin), 1);
      if (exp_lat >= 0) chk("first_rd_cycle", first, exp_lat);
      chk("rd_en_count", n_rd, 6 * 32 + 32);
      chk("out_valid_count", n_ov, 32);
      chk("done_count", n_done, 1);
   endtask

   initial begin : stim
      int a, b, tw;
      chk("rev6_1", rev6(1), 32);
      chk("rev6_3", rev6(3), 48);
      chk("rev6_6", rev6(6), 24);
      bf_ref(0, 3, a, b, tw); chk("s0j3_a", a, 6); chk("s0j3_b", b, 7); chk("s0j3_tw", tw, 0);
      bf_ref(2, 5, a, b, tw); chk("s2j5_a", a, 9); chk("s2j5_b", b, 13); chk("s2j5_tw", tw, 8);
      bf_ref(5, 5, a, b, tw); chk("s5j5_a", a, 5); chk("s5j5_b", b, 37); chk("s5j5_tw", tw, 5);

      nrst = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk_zero("reset");
      nrst = 1'b1;
      idle(2);
      run_frame(0, 0, 65, 1'b0);
      idle(3);
      run_frame(1, 1, 128, 1'b0);
      idle(3);
      run_frame(2, 1, -1, 1'b1);
      idle(2);
      run_frame(2, 1, -1, 1'b0);
      idle(3);
      run_frame(0, 1, 65, 1'b0);
      idle(2);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
